// File: rtl/el_scan_gen.sv
// EL panel scan generator: dual-half raster timing, shift clock and
// ping-pong bank control for a split-screen electroluminescent display.
module el_scan_gen #(
    parameter int H_ACT = 640,
    parameter int V_ACT = 240,
    parameter int DW    = 4,
    parameter int H_BLK = 8,
    parameter int HS_W  = 2,
    parameter int V_BLK = 2,
    parameter int DIV   = 5,
    parameter int AW    = $clog2(H_ACT / DW * V_ACT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          wr_frame_done,
    input  logic [DW-1:0] up_data,
    input  logic [DW-1:0] dn_data,
    output logic [AW-1:0] rd_addr,
    output logic          rd_bank,
    output logic          tr_clk,
    output logic          hsync,
    output logic          vsync,
    output logic [DW-1:0] ud,
    output logic [DW-1:0] ld,
    output logic [15:0]   frame_cnt
);
    localparam int COLS   = H_ACT / DW;
    localparam int LBEATS = COLS + H_BLK;
    localparam int LINES  = V_ACT + V_BLK;
    localparam int BW     = $clog2(LBEATS + 1);
    localparam int LW     = $clog2(LINES + 1);
    localparam int CW     = $clog2(DIV + 1);

    localparam logic [BW-1:0] B_COLS = BW'(COLS);
    localparam logic [BW-1:0] B_HSE  = BW'(COLS + HS_W);
    localparam logic [BW-1:0] B_LAST = BW'(LBEATS - 1);
    localparam logic [LW-1:0] L_ACT  = LW'(V_ACT);
    localparam logic [LW-1:0] L_LAST = LW'(LINES - 1);
    localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);
    localparam logic [AW-1:0] A_LAST = AW'(COLS * V_ACT - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

    state_t          state;
    logic [CW-1:0]   div;
    logic [BW-1:0]   bx;
    logic [LW-1:0]   ln;
    logic            swap_pend;

    logic            fall;
    logic            wrap_line;
    logic            boundary;
    logic [BW-1:0]   nbx;
    logic [LW-1:0]   nln;
    logic [AW-1:0]   next_addr;

    // Beats begin on the falling edge, so every registered output changes
    // half a shift-clock period before the rising edge that samples it.
    always_comb begin
        fall      = (div == C_LAST) && tr_clk;
        wrap_line = (bx == B_LAST);
        boundary  = wrap_line && (ln == L_LAST);
        nbx       = wrap_line ? '0 : bx + 1'b1;
        nln       = ln;
        if (boundary)
            nln = '0;
        else if (wrap_line)
            nln = ln + 1'b1;
        next_addr = (rd_addr == A_LAST) ? '0 : rd_addr + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            div       <= '0;
            bx        <= '0;
            ln        <= '0;
            swap_pend <= 1'b0;
            rd_addr   <= '0;
            rd_bank   <= 1'b0;
            tr_clk    <= 1'b0;
            hsync     <= 1'b0;
            vsync     <= 1'b0;
            ud        <= '0;
            ld        <= '0;
            frame_cnt <= '0;
        end else begin
            if (wr_frame_done)
                swap_pend <= 1'b1;
            if (state == IDLE) begin
                div     <= '0;
                bx      <= '0;
                ln      <= '0;
                tr_clk  <= 1'b0;
                hsync   <= 1'b0;
                vsync   <= 1'b0;
                ud      <= '0;
                ld      <= '0;
                rd_addr <= '0;
                if (en) begin
                    state   <= ACTIVE;
                    ud      <= up_data;
                    ld      <= dn_data;
                    rd_addr <= next_addr;
                end
            end else begin
                if (div == C_LAST) begin
                    div    <= '0;
                    tr_clk <= ~tr_clk;
                end else begin
                    div <= div + 1'b1;
                end
                if (fall) begin
                    bx <= nbx;
                    ln <= nln;
                    if (boundary) begin
                        frame_cnt <= frame_cnt + 16'd1;
                        if (swap_pend || wr_frame_done) begin
                            rd_bank   <= ~rd_bank;
                            swap_pend <= 1'b0;
                        end
                    end
                    if (boundary && !en) begin
                        state <= IDLE;
                        div   <= '0;
                        hsync <= 1'b0;
                        vsync <= 1'b0;
                        ud    <= '0;
                        ld    <= '0;
                    end else if (nbx < B_COLS && nln < L_ACT) begin
                        state   <= ACTIVE;
                        ud      <= up_data;
                        ld      <= dn_data;
                        rd_addr <= next_addr;
                        hsync   <= 1'b0;
                        vsync   <= 1'b0;
                    end else begin
                        state <= (nln < L_ACT) ? HBLANK : VBLANK;
                        ud    <= '0;
                        ld    <= '0;
                        hsync <= (nbx >= B_COLS) && (nbx < B_HSE);
                        vsync <= (nln == L_ACT);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_el_scan_gen.sv
// Self-checking bench for el_scan_gen: fixed timing table, directed
// corner sequences and a randomized run against a frame-level model.
module tb_el_scan_gen;
    localparam int H_ACT = 16;
    localparam int V_ACT = 4;
    localparam int DW    = 4;
    localparam int H_BLK = 3;
    localparam int HS_W  = 1;
    localparam int V_BLK = 1;
    localparam int DIV   = 2;
    localparam int AW    = 4;
    localparam int COLS  = H_ACT / DW;
    localparam int BEAT  = 2 * DIV;
    localparam int LB    = COLS + H_BLK;
    localparam int FRAME = BEAT * LB * (V_ACT + V_BLK);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          wr_frame_done = 1'b0;
    logic [DW-1:0] up_data = '0;
    logic [DW-1:0] dn_data = '0;
    logic [AW-1:0] rd_addr;
    logic          rd_bank;
    logic          tr_clk;
    logic          hsync;
    logic          vsync;
    logic [DW-1:0] ud;
    logic [DW-1:0] ld;
    logic [15:0]   frame_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    el_scan_gen #(
        .H_ACT(H_ACT), .V_ACT(V_ACT), .DW(DW), .H_BLK(H_BLK),
        .HS_W(HS_W), .V_BLK(V_BLK), .DIV(DIV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .wr_frame_done(wr_frame_done),
        .up_data(up_data), .dn_data(dn_data),
        .rd_addr(rd_addr), .rd_bank(rd_bank), .tr_clk(tr_clk),
        .hsync(hsync), .vsync(vsync), .ud(ud), .ld(ld),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Frame buffer with one-cycle read latency
    always @(posedge clk) begin
        up_data <= rd_addr;
        dn_data <= ~rd_addr;
    end

    // Reference model: running flag, clk offset within frame, bank state
    bit m_run  = 0;
    bit m_bank = 0;
    bit m_pend = 0;
    int m_t    = 0;
    int m_frames = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0; m_t = 0; m_frames = 0; m_bank = 0; m_pend = 0;
        end else begin
            m_pend = m_pend | wr_frame_done;
            if (m_run) begin
                m_t = m_t + 1;
                if (m_t == FRAME) begin
                    m_t = 0;
                    m_frames = (m_frames + 1) % 65536;
                    if (m_pend) begin
                        m_bank = !m_bank;
                        m_pend = 0;
                    end
                    if (!en) m_run = 0;
                end
            end else if (en) begin
                m_run = 1;
                m_t = 0;
            end
        end
    end

    bit chk_on = 0;

    always @(negedge clk) begin : model_chk
        int g, line, col, a, na;
        logic etr, ehs, evs;
        logic [DW-1:0] eud, eld;
        logic [AW-1:0] ea;
        logic [31:0] got, expv;
        if (chk_on) begin
            etr = 0; ehs = 0; evs = 0; eud = '0; eld = '0; ea = '0;
            if (m_run) begin
                g = m_t / BEAT;
                line = g / LB;
                col = g % LB;
                etr = ((m_t / DIV) % 2) == 1;
                if (line < V_ACT && col < COLS) begin
                    a = line * COLS + col;
                    eud = a[DW-1:0];
                    eld = ~a[DW-1:0];
                end
                ehs = (col >= COLS) && (col < COLS + HS_W);
                evs = (line == V_ACT);
                if (line < V_ACT)
                    na = line * COLS + ((col < COLS) ? col + 1 : COLS);
                else
                    na = V_ACT * COLS;
                na = na % (V_ACT * COLS);
                ea = na[AW-1:0];
            end
            got  = {tr_clk, hsync, vsync, ud, ld, rd_addr, rd_bank, frame_cnt};
            expv = {etr, ehs, evs, eud, eld, ea, m_bank, 16'(m_frames)};
            n_tests++;
            if (got !== expv) begin
                n_fail++;
                $display("FAIL model t=%0d got %h required %h", m_t, got, expv);
            end
        end
    end

    task automatic chk(input string nm, input int got, input int expv);
        n_tests++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", nm, got, expv);
        end
    endtask

    task automatic wait_t(input int t, input string nm);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(m_run && m_t == t) && k < 2 * FRAME);
        if (!(m_run && m_t == t)) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout %s", nm);
        end
    endtask

    typedef struct {
        int t;
        logic tr, hs, vs;
        logic [3:0] ud, ld, addr;
        int fc;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int t, rises, vs_beats, hs_vb, nz, fc0, busy;
        logic prev;

        tbl[0]  = '{0,   1'b0, 1'b0, 1'b0, 4'h0, 4'hF, 4'd1, 0};
        tbl[1]  = '{2,   1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 4'd1, 0};
        tbl[2]  = '{5,   1'b0, 1'b0, 1'b0, 4'h1, 4'hE, 4'd2, 0};
        tbl[3]  = '{14,  1'b1, 1'b0, 1'b0, 4'h3, 4'hC, 4'd4, 0};
        tbl[4]  = '{16,  1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'd4, 0};
        tbl[5]  = '{20,  1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'd4, 0};
        tbl[6]  = '{28,  1'b0, 1'b0, 1'b0, 4'h4, 4'hB, 4'd5, 0};
        tbl[7]  = '{43,  1'b1, 1'b0, 1'b0, 4'h7, 4'h8, 4'd8, 0};
        tbl[8]  = '{99,  1'b1, 1'b0, 1'b0, 4'hF, 4'h0, 4'd0, 0};
        tbl[9]  = '{104, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'd0, 0};
        tbl[10] = '{112, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'd0, 0};
        tbl[11] = '{128, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'd0, 0};
        tbl[12] = '{139, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 4'd0, 0};
        tbl[13] = '{140, 1'b0, 1'b0, 1'b0, 4'h0, 4'hF, 4'd1, 1};

        repeat (3) @(negedge clk);
        chk("rst_outs", int'({tr_clk, hsync, vsync, ud, ld, rd_addr}), 0);
        chk("rst_fcnt", int'(frame_cnt), 0);
        rst_n = 1'b1;
        chk_on = 1;
        @(negedge clk);
        en = 1'b1;

        t = -1;
        for (int i = 0; i < 14; i++) begin
            while (t < tbl[i].t) begin
                @(negedge clk);
                t++;
            end
            chk($sformatf("tbl%0d_tr", i), int'(tr_clk), int'(tbl[i].tr));
            chk($sformatf("tbl%0d_hs", i), int'(hsync), int'(tbl[i].hs));
            chk($sformatf("tbl%0d_vs", i), int'(vsync), int'(tbl[i].vs));
            chk($sformatf("tbl%0d_ud", i), int'(ud), int'(tbl[i].ud));
            chk($sformatf("tbl%0d_ld", i), int'(ld), int'(tbl[i].ld));
            chk($sformatf("tbl%0d_addr", i), int'(rd_addr), int'(tbl[i].addr));
            chk($sformatf("tbl%0d_fc", i), int'(frame_cnt), tbl[i].fc);
        end

        // vsync spans one whole blanking line; hsync still pulses there
        vs_beats = 0; hs_vb = 0; nz = 0;
        prev = tr_clk;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (tr_clk && !prev && vsync) vs_beats++;
            if (tr_clk && !prev && vsync && hsync) hs_vb++;
            if ((hsync || vsync) && (ud != 0 || ld != 0)) nz++;
            prev = tr_clk;
        end
        chk("vsync_beats", vs_beats, 7);
        chk("hsync_in_vblank", hs_vb, 1);
        chk("blank_data_zero", nz, 0);

        // two mid-frame write pulses give exactly one swap
        wait_t(30, "wfd1");
        wr_frame_done = 1'b1;
        @(negedge clk);
        wr_frame_done = 1'b0;
        wait_t(80, "wfd2");
        wr_frame_done = 1'b1;
        @(negedge clk);
        wr_frame_done = 1'b0;
        wait_t(139, "bank_hold");
        chk("bank_hold", int'(rd_bank), 0);
        @(negedge clk);
        chk("bank_swap", int'(rd_bank), 1);
        wait_t(139, "bank_stay");
        @(negedge clk);
        chk("bank_stay", int'(rd_bank), 1);

        // pulse seen on the boundary edge itself
        wait_t(139, "coinc");
        wr_frame_done = 1'b1;
        @(negedge clk);
        wr_frame_done = 1'b0;
        chk("bank_coinc", int'(rd_bank), 0);
        wait_t(139, "pend_clear");
        @(negedge clk);
        chk("pend_clear", int'(rd_bank), 0);

        // en dropped in line 1: frame finishes, then idle
        wait_t(40, "en_drop");
        en = 1'b0;
        fc0 = m_frames;
        wait_t(139, "en_drop_end");
        chk("fc_before_end", int'(frame_cnt), fc0);
        @(negedge clk);
        chk("fc_after_end", int'(frame_cnt), (fc0 + 1) % 65536);
        busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tr_clk || hsync || vsync) busy++;
        end
        chk("idle_quiet", busy, 0);
        chk("idle_fcnt", int'(frame_cnt), (fc0 + 1) % 65536);

        // asynchronous reset in line 2
        en = 1'b1;
        wait_t(60, "rst_mid");
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_outs", int'({tr_clk, hsync, vsync, ud, ld, rd_addr}), 0);
        chk("arst_bank", int'(rd_bank), 0);
        chk("arst_fcnt", int'(frame_cnt), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("restart_addr0", int'(rd_addr), 0);
        @(negedge clk);
        chk("restart_ud", int'(ud), 0);
        chk("restart_ld", int'(ld), 15);
        chk("restart_fcnt", int'(frame_cnt), 0);

        // randomized enable and write-done traffic
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 299) == 0) en = ~en;
            wr_frame_done = ($urandom_range(0, 99) == 0);
        end
        wr_frame_done = 1'b0;
        @(negedge clk);
        chk_on = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/el_scan_gen.md
EL_SCAN_GEN -- requirements
Module: el_scan_gen

Interface
REQ-001 SHALL have parameter H_ACT, default 640, meaning active pixels per panel line.
REQ-002 SHALL have parameter V_ACT, default 240, meaning lines per panel half (upper/lower scanned in parallel).
REQ-003 SHALL have parameter DW, default 4, meaning pixels per tr_clk beat per half.
REQ-004 SHALL have parameter H_BLK, default 8, meaning horizontal blanking beats per line.
REQ-005 SHALL have parameter HS_W, default 2, meaning hsync width in beats (1 <= HS_W <= H_BLK).
REQ-006 SHALL have parameter V_BLK, default 2, meaning vertical blanking lines per frame.
REQ-007 SHALL have parameter DIV, default 5, meaning clk cycles per tr_clk half-period (DIV >= 2).
REQ-008 SHALL have derived parameter AW = ceil(log2(H_ACT/DW*V_ACT)), meaning read address width.
REQ-009 clk  in  1  scan clock; all logic on rising edge.
REQ-010 rst_n  in  1  reset; asynchronous, active-low.
REQ-011 en  in  1  scan enable.
REQ-012 wr_frame_done  in  1  single-cycle pulse: writer finished the non-displayed bank (already in clk domain).
REQ-013 up_data  in  DW  upper-half pixel word, valid 1 clk after rd_addr.
REQ-014 dn_data  in  DW  lower-half pixel word, valid 1 clk after rd_addr.
REQ-015 rd_addr  out  AW  frame buffer read address.
REQ-016 rd_bank  out  1  displayed bank select for ping-pong buffer.
REQ-017 tr_clk  out  1  panel shift clock.
REQ-018 hsync  out  1  panel line sync, active-high.
REQ-019 vsync  out  1  panel frame sync, active-high.
REQ-020 ud  out  DW  upper-half panel data.
REQ-021 ld  out  DW  lower-half panel data.
REQ-022 frame_cnt  out  16  completed frames, wraps 0xFFFF->0.

Function
REQ-023 Divider counts 0..DIV-1; on wrap tr_clk toggles; "beat" = clk cycle where tr_clk goes 0->1.
REQ-024 States: IDLE, ACTIVE, HBLANK, VBLANK; IDLE holds tr_clk, hsync, vsync, ud, ld at 0 and divider at 0.
REQ-025 IDLE->ACTIVE when en=1, starting line 0 column 0; first tr_clk rise DIV clks later.
REQ-026 ACTIVE: H_ACT/DW beats per line; ud/ld updated on tr_clk falling edge so stable across rising edge.
REQ-027 rd_addr = line*(H_ACT/DW)+col, issued at least 1 clk before the falling edge that loads ud/ld.
REQ-028 HBLANK: H_BLK beats, ud/ld=0, hsync=1 for first HS_W beats; then next line ACTIVE, or VBLANK after line V_ACT-1.
REQ-029 VBLANK: V_BLK lines of (H_ACT/DW + H_BLK) beats, ud/ld=0, tr_clk running, vsync=1 for the whole first VBLANK line, hsync per REQ-028 timing.
REQ-030 End of VBLANK = frame boundary: frame_cnt increments; if en=0 go IDLE, else ACTIVE line 0.
REQ-031 en deassert mid-frame SHALL NOT truncate; frame completes per REQ-030.
REQ-032 wr_frame_done sets swap_pend; at frame boundary, if swap_pend, rd_bank toggles and swap_pend clears.
REQ-033 wr_frame_done coincident with boundary SHALL swap at that boundary; multiple pulses within one frame give one swap.
REQ-034 rd_bank SHALL change only at frame boundary, never mid-frame.

Reset
REQ-035 rst_n low SHALL immediately force IDLE, tr_clk/hsync/vsync/ud/ld/rd_addr/rd_bank/frame_cnt/swap_pend to 0, divider to 0.
REQ-036 After rst_n release, first activity only per REQ-025; mid-frame reset discards the partial frame.

Verification (H_ACT=16, DW=4, V_ACT=4, H_BLK=3, HS_W=1, V_BLK=1, DIV=2: line = 7 beats = 28 clk, frame = 5 lines = 140 clk)
REQ-037 en=1 after reset, up_data=rd_addr[3:0] -> ud sequence 0,1,2,3 line 0, 4..7 line 1; hsync 1 beat after 4th data beat; frame_cnt=1 at 140 clk.
REQ-038 Check vsync high exactly 7 beats (line 4), hsync still pulses there, ud/ld=0 throughout blanking.
REQ-039 wr_frame_done pulsed twice mid-frame -> rd_bank 0->1 at next boundary only; no pulse next frame -> stays 1.
REQ-040 wr_frame_done on the boundary clk -> rd_bank toggles that boundary, swap_pend=0 afterwards.
REQ-041 en dropped at line 1 -> frame completes, frame_cnt increments once, then IDLE with tr_clk=0.
REQ-042 rst_n low in line 2 -> all outputs 0 same cycle; re-enable restarts at rd_addr=0, frame_cnt=0.
